// File: rtl/tone_gen_pkg.sv
// Shared constants for the tone generator blocks.
// Register map and phase-generator state encoding.
package tone_gen_pkg;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_LEN    = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_PHASE  = 2'd3;

    localparam int ADDR_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/phase_divider.sv
// Tick-driven down counter that reloads from the period register.
// Terminal count is flagged while the counter sits at zero.
module phase_divider #(
    parameter int PERIOD_W = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tc_o
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    assign tc_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = period_i;
        end else if (en_i) begin
            cnt_d = tc_o ? period_i : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wave_phase_gen.sv
// Wave table phase generator: register file, RUN/IDLE FSM and
// one-shot length tracking around a tick-driven period divider.
module wave_phase_gen
    import tone_gen_pkg::*;
#(
    parameter int PERIOD_W = 12,
    parameter int LEN_W    = 8
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                tick_in,
    input  logic                reg_wr_en_in,
    input  logic [1:0]          reg_addr_in,
    input  logic [PERIOD_W-1:0] reg_data_in,
    output logic [ADDR_W-1:0]   lut_addr_out,
    output logic                step_out,
    output logic                active_out
);

    state_e              state_q;
    logic [PERIOD_W-1:0] period_q;
    logic [LEN_W-1:0]    len_cfg_q;
    logic                oneshot_q;
    logic [LEN_W-1:0]    len_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                step_q;

    logic wr_ctrl;
    logic key_on;
    logic key_off;
    logic phase_rst;
    logic div_load;
    logic div_en;
    logic div_tc;
    logic advance;
    logic wrap;

    assign wr_ctrl   = reg_wr_en_in && (reg_addr_in == REG_CTRL);
    assign key_on    = wr_ctrl && reg_data_in[0];
    assign key_off   = wr_ctrl && !reg_data_in[0];
    assign phase_rst = reg_wr_en_in && (reg_addr_in == REG_PHASE);

    // Control writes own the divider for their cycle, so no step slips through.
    assign div_load = key_on || phase_rst;
    assign div_en   = (state_q == ST_RUN) && tick_in && !wr_ctrl && !phase_rst;
    assign advance  = div_en && div_tc;
    assign wrap     = (addr_q == '1);

    phase_divider #(
        .PERIOD_W (PERIOD_W)
    ) u_div (
        .clk_i    (clk_in),
        .rst_ni   (reset_in),
        .load_i   (div_load),
        .en_i     (div_en),
        .period_i (period_q),
        .tc_o     (div_tc)
    );

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            len_cfg_q <= '0;
            oneshot_q <= 1'b0;
            len_cnt_q <= '0;
            addr_q    <= '0;
            step_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (reg_wr_en_in && (reg_addr_in == REG_PERIOD)) begin
                period_q <= reg_data_in;
            end
            if (reg_wr_en_in && (reg_addr_in == REG_LEN)) begin
                len_cfg_q <= reg_data_in[LEN_W-1:0];
                oneshot_q <= reg_data_in[LEN_W];
            end
            if (key_on) begin
                state_q   <= ST_RUN;
                addr_q    <= '0;
                len_cnt_q <= len_cfg_q;
            end else if (key_off) begin
                state_q <= ST_IDLE;
            end else if (phase_rst) begin
                addr_q <= '0;
            end else if (advance) begin
                step_q <= 1'b1;
                addr_q <= addr_q + 1'b1;
                // One-shot: the wrap with an exhausted count ends the note.
                if (wrap && oneshot_q) begin
                    if (len_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        len_cnt_q <= len_cnt_q - 1'b1;
                    end
                end
            end
        end
    end

    assign lut_addr_out = addr_q;
    assign step_out     = step_q;
    assign active_out   = (state_q == ST_RUN);

endmodule

// File: doc/wave_phase_gen.md
WAVE_PHASE_GEN -- requirements
Module: wave_phase_gen

Interface
REQ-001 SHALL have parameter PERIOD_W, default 12, meaning width of the period divider.
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of the one-shot length counter.
REQ-003 SHALL have port clk_in  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset_in  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port tick_in  input  1  prescaler enable, one-cycle pulse; the divider advances only when it is 1.
REQ-006 SHALL have port reg_wr_en_in  input  1  register write strobe.
REQ-007 SHALL have port reg_addr_in  input  2  register select: 0 period, 1 length/mode, 2 control, 3 phase reset.
REQ-008 SHALL have port reg_data_in  input  PERIOD_W  register write data.
REQ-009 SHALL have port lut_addr_out  output  5  wave table address, feeds wave_lut lut_addr_in.
REQ-010 SHALL have port step_out  output  1  one-cycle pulse on each address advance; clocks noise LFSR downstream.
REQ-011 SHALL have port active_out  output  1  1 while in RUN state.

Function
REQ-012 SHALL hold registers period_r (PERIOD_W), len_cfg_r (LEN_W), oneshot_r (1), div_cnt (PERIOD_W), len_cnt (LEN_W), addr_r (5), state (IDLE/RUN).
REQ-013 Write addr 0 SHALL load period_r; the running divider uses the new value only at its next reload, with no immediate change to div_cnt.
REQ-014 Write addr 1 SHALL load len_cfg_r from reg_data_in[LEN_W-1:0] and oneshot_r from reg_data_in[LEN_W].
REQ-015 Write addr 2 with data[0]=1 (key-on) SHALL enter RUN, with addr_r=0, div_cnt=period_r, len_cnt=len_cfg_r, all on the next edge, from either state.
REQ-016 Write addr 2 with data[0]=0 (key-off) SHALL enter IDLE next edge; addr_r SHALL hold its value.
REQ-017 Write addr 3 (any data) SHALL set addr_r=0 and div_cnt=period_r, leaving state and len_cnt unchanged.
REQ-018 In RUN, a cycle with tick_in=1 and div_cnt!=0 SHALL decrement div_cnt.
REQ-019 In RUN, a cycle with tick_in=1 and div_cnt==0 SHALL reload div_cnt=period_r, increment addr_r modulo 32 (31 wraps to 0), and assert step_out in the following cycle; one step therefore occurs every period_r+1 ticks.
REQ-020 period_r==0 with tick_in held at 1 SHALL advance addr_r on every tick.
REQ-021 In IDLE, div_cnt, addr_r and len_cnt SHALL hold, and step_out SHALL stay 0.
REQ-022 With oneshot_r=1, each 31->0 wrap of addr_r SHALL decrement len_cnt; a wrap with len_cnt==0 SHALL leave addr_r at 0 and enter IDLE (len_cfg_r+1 full cycles played).
REQ-023 With oneshot_r=0, len_cnt SHALL be ignored and RUN SHALL persist until key-off.
REQ-024 A register write and a tick in the same cycle SHALL give the write priority for the fields it touches; a key-on or phase reset SHALL suppress that cycle's step.
REQ-025 All outputs SHALL be registered; lut_addr_out SHALL equal addr_r and active_out SHALL equal (state==RUN).

Reset
REQ-026 reset_in=0 SHALL asynchronously clear all registers: state=IDLE, period_r=0, len_cfg_r=0, oneshot_r=0, div_cnt=0, len_cnt=0, addr_r=0.
REQ-027 During reset, outputs SHALL be lut_addr_out=0, step_out=0, active_out=0.
REQ-028 Reset asserted mid-RUN SHALL abort immediately with no step pulse, and the block SHALL stay IDLE after release until a key-on.

Structure
REQ-029 The register address constants (REG_PERIOD=0, REG_LEN=1, REG_CTRL=2, REG_PHASE=3) and the state encoding SHALL live in a shared package tone_gen_pkg.
REQ-030 The divider SHALL be a sub-module phase_divider (div_cnt, reload, terminal-count output); the FSM and registers SHALL live in wave_phase_gen.

Verification
REQ-031 period=3, oneshot=0, key-on, tick_in=1 continuous -> step_out every 4 cycles; lut_addr_out goes 0,1,2…31,0.
REQ-032 period=0, len=1, oneshot=1, key-on, tick continuous -> 64 steps, then active_out=0 and lut_addr_out=0.
REQ-033 Running with period=5, write period=1 mid-count -> current interval stays 6 ticks, later intervals are 2 ticks.
REQ-034 Key-on and tick in the same cycle, with addr at 17 -> addr=0, div_cnt=period, no step_out that cycle.
REQ-035 reset_in pulled low mid-RUN between clock edges -> outputs go 0 at once, and no activity after release until key-on.
REQ-036 Key-off at addr=9, then phase-reset write -> active_out=0, lut_addr_out shows 9 then 0, and step_out never pulses.
